// File: rtl/result_mux_pkg.sv
// Shared encodings for the writeback result selector: source select and load funct3.
package result_mux_pkg;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10,
    RES_IMM = 2'b11
  } res_src_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/result_mux_load_ext.sv
// Load formatter: extracts a byte/halfword from the raw read word and sign/zero extends it.
module load_ext
  import result_mux_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      off_i,
  input  logic [XLEN-1:0] data_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Halfword offset uses only off[1]; off[0] misalignment is ignored.
  assign byte_sel = data_i[{off_i, 3'b000} +: 8];
  assign half_sel = off_i[1] ? data_i[31:16] : data_i[15:0];

  always_comb begin
    data_o = data_i;
    case (funct3_i)
      F3_LB:   data_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LH:   data_o = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LBU:  data_o = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LHU:  data_o = {{(XLEN-16){1'b0}}, half_sel};
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/result_mux.sv
// Writeback result selector with combinational output and registered writeback copy.
// Define RESULT_MUX_LOAD_EXT_EN to add LoadFunct3 and format the ReadData path.
module result_mux
  import result_mux_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      ResultSrc,
  input  logic [XLEN-1:0] ALU_result,
  input  logic [XLEN-1:0] ReadData,
  input  logic [XLEN-1:0] PC_plus4,
  input  logic [XLEN-1:0] ImmExt,
`ifdef RESULT_MUX_LOAD_EXT_EN
  input  logic [2:0]      LoadFunct3,
`endif
  input  logic            WbEn,
  output logic [XLEN-1:0] ResultOut,
  output logic [XLEN-1:0] ResultOut_q,
  output logic            WbValid_q
);

  logic [XLEN-1:0] mem_data;
  logic [XLEN-1:0] result_d;
  logic            valid_d;

`ifdef RESULT_MUX_LOAD_EXT_EN
  load_ext #(.XLEN(XLEN)) u_load_ext (
    .funct3_i (LoadFunct3),
    .off_i    (ALU_result[1:0]),
    .data_i   (ReadData),
    .data_o   (mem_data)
  );
`else
  assign mem_data = ReadData;
`endif

  always_comb begin
    ResultOut = ALU_result;
    case (res_src_e'(ResultSrc))
      RES_ALU: ResultOut = ALU_result;
      RES_MEM: ResultOut = mem_data;
      RES_PC4: ResultOut = PC_plus4;
      RES_IMM: ResultOut = ImmExt;
      default: ResultOut = ALU_result;
    endcase
  end

  // Value holds when WbEn is low; only the valid flag drops.
  always_comb begin
    result_d = WbEn ? ResultOut : ResultOut_q;
    valid_d  = WbEn;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ResultOut_q <= '0;
      WbValid_q   <= 1'b0;
    end else begin
      ResultOut_q <= result_d;
      WbValid_q   <= valid_d;
    end
  end

endmodule

// File: tb/tb_result_mux.sv
// Randomized self-checking bench for result_mux against a behavioural model.
module tb_result_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  ResultSrc;
  logic [31:0] ALU_result, ReadData, PC_plus4, ImmExt;
  logic        WbEn;
  logic [31:0] ResultOut, ResultOut_q;
  logic        WbValid_q;
`ifdef RESULT_MUX_LOAD_EXT_EN
  logic [2:0]  LoadFunct3;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_q;
  logic        exp_v;
  logic        model_ok = 1'b0;

  always #10 clk = ~clk;

  result_mux #(.XLEN(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ResultSrc   (ResultSrc),
    .ALU_result  (ALU_result),
    .ReadData    (ReadData),
    .PC_plus4    (PC_plus4),
    .ImmExt      (ImmExt),
`ifdef RESULT_MUX_LOAD_EXT_EN
    .LoadFunct3  (LoadFunct3),
`endif
    .WbEn        (WbEn),
    .ResultOut   (ResultOut),
    .ResultOut_q (ResultOut_q),
    .WbValid_q   (WbValid_q)
  );

  // Memory value as a load would see it, written with shifts and signed casts.
  function automatic logic [31:0] model_mem();
    logic [31:0] w;
    w = ReadData;
`ifdef RESULT_MUX_LOAD_EXT_EN
    begin
      logic [7:0]  b;
      logic [15:0] h;
      b = 8'(ReadData >> (8 * int'(ALU_result[1:0])));
      h = 16'(ReadData >> (16 * int'(ALU_result[1])));
      case (LoadFunct3)
        3'd0: w = 32'($signed(b));
        3'd1: w = 32'($signed(h));
        3'd4: w = {24'd0, b};
        3'd5: w = {16'd0, h};
        default: w = ReadData;
      endcase
    end
`endif
    return w;
  endfunction

  function automatic logic [31:0] model_out();
    logic [31:0] srcs [4];
    srcs[0] = ALU_result;
    srcs[1] = model_mem();
    srcs[2] = PC_plus4;
    srcs[3] = ImmExt;
    return srcs[ResultSrc];
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      exp_q    = 32'd0;
      exp_v    = 1'b0;
      model_ok = 1'b1;
    end else if (WbEn) begin
      exp_q = model_out();
      exp_v = 1'b1;
    end else begin
      exp_v = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("comb_out", ResultOut, model_out());
      check("reg_out", ResultOut_q, exp_q);
      check("reg_valid", {31'd0, WbValid_q}, {31'd0, exp_v});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] lit [4];
    lit[0] = 32'h0000000A; lit[1] = 32'hDEADBEEF; lit[2] = 32'h00000004; lit[3] = 32'h12345000;
    rst_n      = 1'b0;
    WbEn       = 1'b1;
    ResultSrc  = 2'b00;
    ALU_result = 32'h0000000A;
    ReadData   = 32'hDEADBEEF;
    PC_plus4   = 32'h00000004;
    ImmExt     = 32'h12345000;
`ifdef RESULT_MUX_LOAD_EXT_EN
    LoadFunct3 = 3'b010;
`endif
    @(negedge clk); #1;
    // Source select under reset; spans two rising edges.
    for (int s = 0; s < 4; s++) begin
      ResultSrc = 2'(s);
      #10;
      check($sformatf("src_%0d", s), ResultOut, lit[s]);
    end
    check("reset_q", ResultOut_q, 32'h0);
    check("reset_valid", {31'd0, WbValid_q}, 32'd0);

    @(negedge clk); #1;
    rst_n = 1'b1; WbEn = 1'b1; ResultSrc = 2'b11;
    @(posedge clk); #1;
    check("capture_q", ResultOut_q, 32'h12345000);
    check("capture_valid", {31'd0, WbValid_q}, 32'd1);

    WbEn = 1'b0; ResultSrc = 2'b01;
    @(posedge clk); #1;
    check("hold_q", ResultOut_q, 32'h12345000);
    check("hold_valid", {31'd0, WbValid_q}, 32'd0);
    check("hold_comb", ResultOut, 32'hDEADBEEF);

`ifdef RESULT_MUX_LOAD_EXT_EN
    begin
      logic [2:0]  f3s  [6];
      logic [31:0] exps [6];
      f3s[0] = 3'b000; exps[0] = 32'hFFFFFFAD;
      f3s[1] = 3'b100; exps[1] = 32'h000000AD;
      f3s[2] = 3'b001; exps[2] = 32'hFFFFDEAD;
      f3s[3] = 3'b101; exps[3] = 32'h0000DEAD;
      f3s[4] = 3'b010; exps[4] = 32'hDEADBEEF;
      f3s[5] = 3'b111; exps[5] = 32'hDEADBEEF;
      @(negedge clk); #1;
      for (int i = 0; i < 6; i++) begin
        LoadFunct3 = f3s[i];
        #1;
        check($sformatf("load_f3_%0d", f3s[i]), ResultOut, exps[i]);
      end
    end
`endif

    repeat (500) begin
      @(negedge clk); #1;
      rst_n      = ($urandom_range(0, 15) != 0);
      WbEn       = 1'($urandom_range(0, 1));
      ResultSrc  = 2'($urandom_range(0, 3));
      ALU_result = $urandom;
      ReadData   = $urandom;
      PC_plus4   = $urandom;
      ImmExt     = $urandom;
`ifdef RESULT_MUX_LOAD_EXT_EN
      LoadFunct3 = 3'($urandom_range(0, 7));
`endif
    end

    @(negedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/result_mux.md
# result_mux

Writeback result selector for the single-issue RV32 core. It picks the register-file write value from four sources: ALU result, data-memory read data, PC+4 and the extended immediate. It presents the selection combinationally and also as a registered writeback copy. It sits between the execute/memory stage outputs and the register-file write port.

## Interface
Parameters:
- `XLEN`, default 32: datapath width. Only 32 is supported.

Ports:
- `clk`  input  1: the single clock. All sequential logic uses its rising edge.
- `rst_n`  input  1: reset, synchronous and active-low.
- `ResultSrc`  input  2: source select. 00 = ALU_result, 01 = ReadData, 10 = PC_plus4, 11 = ImmExt.
- `ALU_result`  input  32: ALU output. Under the macro, bits [1:0] are also the load byte offset.
- `ReadData`  input  32: raw data-memory read word.
- `PC_plus4`  input  32: link value for JAL/JALR.
- `ImmExt`  input  32: extended immediate, used for LUI.
- `WbEn`  input  1: capture enable for the registered copy.
- `ResultOut`  output  32: combinational selected result.
- `ResultOut_q`  output  32: registered result.
- `WbValid_q`  output  1: registered `WbEn`.
- `LoadFunct3`  input  3: load type. This port exists only when `RESULT_MUX_LOAD_EXT_EN` is defined.

## Operation
- `ResultOut` is a pure 4:1 selection per `ResultSrc`. All four encodings are defined; there are no X outputs.
- Without the macro, the ReadData path passes through unmodified.
- The registered stage works as follows on each rising edge:
  - If `rst_n` = 0: `ResultOut_q` ← 0 and `WbValid_q` ← 0. Reset has priority over everything else.
  - Otherwise, if `WbEn` = 1: `ResultOut_q` ← `ResultOut` and `WbValid_q` ← 1.
  - Otherwise: `ResultOut_q` holds its value and `WbValid_q` ← 0.
- No internal state other than these two registers.

## Timing
- `ResultOut` has zero-cycle latency. It settles within the same cycle as any input change and is independent of `clk` and `rst_n`.
- `ResultOut_q` and `WbValid_q` have one-cycle latency from inputs sampled with `WbEn` = 1.
- Reset values are 0x00000000 and 0. `rst_n` has no effect between edges.
- If reset is asserted mid-stream, the captured value is discarded on that edge and `ResultOut` stays live.
- `WbEn` held high makes the registered copy track `ResultOut` delayed by one cycle.

## Configuration
- Macro `RESULT_MUX_LOAD_EXT_EN`.
- When defined, the `LoadFunct3` port exists and the ReadData path is formatted. Let off = `ALU_result[1:0]`.
  - 000 LB: sign-extend byte at off.
  - 001 LH: sign-extend halfword at `off[1]`; `off[0]` is ignored.
  - 010 LW: word unchanged.
  - 100 LBU: zero-extend byte at off.
  - 101 LHU: zero-extend halfword at `off[1]`.
  - 011, 110, 111: word unchanged.
- When undefined, the port is absent and ReadData is used raw. Other sources are unaffected either way.

## Structure
- Package `result_mux_pkg` holds:
  - `ResultSrc` encodings: `RES_ALU`, `RES_MEM`, `RES_PC4`, `RES_IMM`.
  - Load funct3 constants: `F3_LB`, `F3_LH`, `F3_LW`, `F3_LBU`, `F3_LHU`.
- One sub-module, `load_ext`, does byte/halfword extraction and extension. It is instantiated only under the macro.

## Test plan
Common inputs: ALU_result = 0000000A, ReadData = DEADBEEF, PC_plus4 = 00000004, ImmExt = 12345000, `LoadFunct3` = 010 when present.
- Source select: `ResultSrc` = 00/01/10/11 → `ResultOut` = 0000000A / DEADBEEF / 00000004 / 12345000, checked 10 time units after each change.
- Reset: `rst_n` = 0 for 2 edges with `WbEn` = 1 → `ResultOut_q` = 0, `WbValid_q` = 0, and `ResultOut` still follows `ResultSrc`.
- Capture: `WbEn` = 1 with `ResultSrc` = 11 → after 1 edge, `ResultOut_q` = 12345000 and `WbValid_q` = 1.
- Hold: then `WbEn` = 0 and `ResultSrc` = 01 → `ResultOut_q` stays 12345000, `WbValid_q` = 0, `ResultOut` = DEADBEEF.
- Macro on, `ResultSrc` = 01, off = 2 (from 0000000A):
  - LB → FFFFFFAD; LBU → 000000AD; LH → FFFFDEAD; LHU → 0000DEAD; LW → DEADBEEF.
  - LoadFunct3 = 111 → DEADBEEF.
